auto_song_memory: RTL and testbench

AUTO_SONG_MEMORY -- requirements
Module: auto_song_memory

---
 rtl/auto_song_memory.sv | 185 ++++++++++++++++++
 tb/tb_auto_song_memory.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/auto_song_memory.sv
// Song memory for the auto-play sequencer: three constant songs plus one writable user song,
// with a small fetch FSM that turns 6-bit entries into registered note/duration outputs.
module auto_song_memory #(
    parameter int unsigned DUR_UNIT = 32'd12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  song_select,
    input  logic        song_load,
    input  logic [4:0]  address,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [3:0]  wr_note,
    input  logic [1:0]  wr_dur,
    output logic [3:0]  note_value,
    output logic [25:0] duration_value,
    output logic        isvalid,
    output logic        wr_ack,
    output logic [1:0]  active_song
);

    localparam logic [3:0] END_NOTE  = 4'd15;
    localparam logic [5:0] END_ENTRY = 6'b1111_00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_END   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [5:0]  user_song_r [32];
    logic [4:0]  addr_cap_r;
    logic [1:0]  active_song_r;
    logic [3:0]  note_r;
    logic [25:0] dur_r;
    logic        isvalid_r;
    logic        wr_ack_r;
    logic [5:0]  entry_s;
    logic [3:0]  note_next_s;
    logic [25:0] dur_next_s;
    logic        isvalid_next_s;

    // Duration code d means (d+1) units; the largest product still fits in 26 bits.
    function automatic logic [25:0] expand_dur(input logic [1:0] d);
        return 26'(({30'd0, d} + 32'd1) * DUR_UNIT);
    endfunction

    function automatic logic [5:0] rom_entry(input logic [1:0] song, input logic [4:0] addr);
        logic [5:0] e;
        e = END_ENTRY;
        case (song)
            2'd0: begin
                case (addr)
                    5'd0:    e = {4'd1,  2'd0};
                    5'd1:    e = {4'd3,  2'd1};
                    5'd2:    e = {4'd5,  2'd2};
                    5'd3:    e = {4'd6,  2'd3};
                    5'd4:    e = {4'd8,  2'd0};
                    5'd5:    e = {4'd10, 2'd1};
                    5'd6:    e = {4'd12, 2'd2};
                    5'd7:    e = {4'd13, 2'd3};
                    default: e = END_ENTRY;
                endcase
            end
            2'd1: begin
                case (addr)
                    5'd0:    e = {4'd14, 2'd1};
                    5'd1:    e = {4'd0,  2'd0};
                    5'd2:    e = {4'd12, 2'd1};
                    5'd3:    e = {4'd0,  2'd0};
                    5'd4:    e = {4'd10, 2'd3};
                    5'd5:    e = {4'd9,  2'd2};
                    5'd6:    e = {4'd7,  2'd1};
                    5'd7:    e = {4'd0,  2'd1};
                    5'd8:    e = {4'd5,  2'd0};
                    5'd9:    e = {4'd4,  2'd0};
                    5'd10:   e = {4'd2,  2'd3};
                    default: e = END_ENTRY;
                endcase
            end
            // Song 2 fills all 32 slots with no end marker, so entry 31 is playable.
            2'd2:    e = {4'((addr % 5'd14) + 5'd1), addr[1:0]};
            default: e = END_ENTRY;
        endcase
        return e;
    endfunction

    // Entry addressed by the sequencer within the active song.
    always_comb begin
        entry_s = END_ENTRY;
        if (active_song_r == 2'd3) begin
            entry_s = user_song_r[address];
        end else begin
            entry_s = rom_entry(active_song_r, address);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; song_load overrides everything else.
    always_comb begin
        state_next_s = state_r;
        if (song_load) begin
            state_next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = ST_IDLE;
                ST_FETCH: state_next_s = (entry_s[5:2] == END_NOTE) ? ST_END : ST_VALID;
                ST_VALID: state_next_s = (address != addr_cap_r) ? ST_FETCH : ST_VALID;
                ST_END:   state_next_s = ST_END;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next output values: loaded only on FETCH, end marker clears them.
    always_comb begin
        note_next_s    = note_r;
        dur_next_s     = dur_r;
        isvalid_next_s = (state_next_s == ST_VALID);
        if (state_r == ST_FETCH) begin
            if (entry_s[5:2] == END_NOTE) begin
                note_next_s = 4'd0;
                dur_next_s  = 26'd0;
            end else begin
                note_next_s = entry_s[5:2];
                dur_next_s  = expand_dur(entry_s[1:0]);
            end
        end else begin
            note_next_s = note_r;
            dur_next_s  = dur_r;
        end
    end

    // Output, song latch and captured-address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            note_r        <= 4'd0;
            dur_r         <= 26'd0;
            isvalid_r     <= 1'b0;
            wr_ack_r      <= 1'b0;
            active_song_r <= 2'd0;
            addr_cap_r    <= 5'd0;
        end else begin
            note_r    <= note_next_s;
            dur_r     <= dur_next_s;
            isvalid_r <= isvalid_next_s;
            wr_ack_r  <= wr_en;
            if (song_load) begin
                active_song_r <= song_select;
            end
            if (state_r == ST_FETCH) begin
                addr_cap_r <= address;
            end
        end
    end

    // User song storage; a same-cycle FETCH sees the pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                user_song_r[i] <= END_ENTRY;
            end
        end else if (wr_en) begin
            user_song_r[wr_addr] <= {wr_note, wr_dur};
        end
    end

    assign note_value     = note_r;
    assign duration_value = dur_r;
    assign isvalid        = isvalid_r;
    assign wr_ack         = wr_ack_r;
    assign active_song    = active_song_r;

endmodule

// File: tb/tb_auto_song_memory.sv
// Self-checking bench for auto_song_memory: directed vector table, hand-written corner
// sequences, then randomized traffic against a cycle-level reference model.
module tb_auto_song_memory;

    localparam int unsigned DU = 32'd12500000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  song_select;
    logic        song_load;
    logic [4:0]  address;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_note;
    logic [1:0]  wr_dur;
    logic [3:0]  note_value;
    logic [25:0] duration_value;
    logic        isvalid;
    logic        wr_ack;
    logic [1:0]  active_song;

    int checks = 0;
    int errors = 0;

    auto_song_memory #(.DUR_UNIT(DU)) dut (
        .clk(clk), .rst(rst), .song_select(song_select), .song_load(song_load),
        .address(address), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
        .wr_dur(wr_dur), .note_value(note_value), .duration_value(duration_value),
        .isvalid(isvalid), .wr_ack(wr_ack), .active_song(active_song)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ld; logic [1:0] sel; logic [4:0] addr;
        logic we; logic [4:0] wa; logic [3:0] wn; logic [1:0] wd;
        logic ev; logic [3:0] en; int unsigned ed; logic ea; logic [1:0] es;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic ld, input logic [1:0] sel, input logic [4:0] addr,
                         input logic we, input logic [4:0] wa, input logic [3:0] wn,
                         input logic [1:0] wd);
        song_load = ld; song_select = sel; address = addr;
        wr_en = we; wr_addr = wa; wr_note = wn; wr_dur = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] n,
                             input int unsigned d);
        check({tag, ".isvalid"}, {31'd0, isvalid}, {31'd0, v});
        check({tag, ".note"}, {28'd0, note_value}, {28'd0, n});
        check({tag, ".dur"}, {6'd0, duration_value}, d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        apply(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 4'd0, 2'd0);
        apply(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 4'd0, 2'd0);
        rst = 1'b1;
    endtask

    // Song contents as listed for the product, {note, dur} per entry.
    function automatic logic [5:0] ref_rom(input int song, input int a);
        int n0 [9]  = '{1, 3, 5, 6, 8, 10, 12, 13, 15};
        int d0 [9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        int n1 [12] = '{14, 0, 12, 0, 10, 9, 7, 0, 5, 4, 2, 15};
        int d1 [12] = '{1, 0, 1, 0, 3, 2, 1, 1, 0, 0, 3, 0};
        int n, d;
        n = 15; d = 0;
        if (song == 0 && a < 9) begin n = n0[a]; d = d0[a]; end
        if (song == 1 && a < 12) begin n = n1[a]; d = d1[a]; end
        if (song == 2) begin n = (a % 14) + 1; d = a % 4; end
        return {n[3:0], d[1:0]};
    endfunction

    vec_t vecs [13];
    logic [5:0] mem [4][32];
    int  m_song, m_last;
    bit  m_pend, m_play;
    logic [3:0] e_note;
    int unsigned e_dur;
    logic e_ack;

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd0, 0,          1'b0, 2'd0};
        vecs[1]  = '{1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 4'd0,  2'd0, 1'b1, 4'd1, DU,         1'b0, 2'd0};
        vecs[2]  = '{1'b0, 2'd0, 5'd1, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd1, DU,         1'b0, 2'd0};
        vecs[3]  = '{1'b0, 2'd0, 5'd1, 1'b0, 5'd0, 4'd0,  2'd0, 1'b1, 4'd3, 2 * DU,     1'b0, 2'd0};
        vecs[4]  = '{1'b0, 2'd0, 5'd1, 1'b0, 5'd0, 4'd0,  2'd0, 1'b1, 4'd3, 2 * DU,     1'b0, 2'd0};
        vecs[5]  = '{1'b0, 2'd0, 5'd1, 1'b1, 5'd0, 4'd5,  2'd2, 1'b1, 4'd3, 2 * DU,     1'b1, 2'd0};
        vecs[6]  = '{1'b0, 2'd0, 5'd1, 1'b1, 5'd1, 4'd15, 2'd1, 1'b1, 4'd3, 2 * DU,     1'b1, 2'd0};
        vecs[7]  = '{1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd3, 2 * DU,     1'b0, 2'd3};
        vecs[8]  = '{1'b0, 2'd3, 5'd0, 1'b0, 5'd0, 4'd0,  2'd0, 1'b1, 4'd5, 32'd37500000, 1'b0, 2'd3};
        vecs[9]  = '{1'b0, 2'd3, 5'd1, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd5, 32'd37500000, 1'b0, 2'd3};
        vecs[10] = '{1'b0, 2'd3, 5'd1, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd0, 0,          1'b0, 2'd3};
        vecs[11] = '{1'b0, 2'd3, 5'd2, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd0, 0,          1'b0, 2'd3};
        vecs[12] = '{1'b0, 2'd3, 5'd0, 1'b0, 5'd0, 4'd0,  2'd0, 1'b0, 4'd0, 0,          1'b0, 2'd3};

        do_reset();
        check_out("reset", 1'b0, 4'd0, 0);
        check("reset.wr_ack", {31'd0, wr_ack}, 32'd0);
        check("reset.active", {30'd0, active_song}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].ld, vecs[i].sel, vecs[i].addr, vecs[i].we, vecs[i].wa,
                  vecs[i].wn, vecs[i].wd);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].en, vecs[i].ed);
            check($sformatf("vec%0d.wr_ack", i), {31'd0, wr_ack}, {31'd0, vecs[i].ea});
            check($sformatf("vec%0d.active", i), {30'd0, active_song}, {30'd0, vecs[i].es});
        end

        // Write and FETCH of the same user entry in one cycle.
        do_reset();
        apply(1'b1, 2'd3, 5'd4, 1'b0, 5'd0, 4'd0, 2'd0);
        apply(1'b0, 2'd3, 5'd4, 1'b1, 5'd4, 4'd9, 2'd3);
        check_out("collide.old", 1'b0, 4'd0, 0);
        check("collide.wr_ack", {31'd0, wr_ack}, 32'd1);
        apply(1'b1, 2'd3, 5'd4, 1'b0, 5'd0, 4'd0, 2'd0);
        check("collide.ack_drop", {31'd0, wr_ack}, 32'd0);
        apply(1'b0, 2'd3, 5'd4, 1'b0, 5'd0, 4'd0, 2'd0);
        check_out("collide.new", 1'b1, 4'd9, 4 * DU);

        // Asynchronous reset while VALID right after writes.
        for (int a = 0; a < 4; a++) apply(1'b0, 2'd3, 5'd4, 1'b1, 5'(a), 4'd7, 2'd1);
        #2 rst = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 4'd0, 0);
        check("async_rst.wr_ack", {31'd0, wr_ack}, 32'd0);
        check("async_rst.active", {30'd0, active_song}, 32'd0);
        apply(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 4'd0, 2'd0);
        rst = 1'b1;
        for (int a = 1; a < 4; a++) begin
            apply(1'b0, 2'd2, 5'(a), 1'b0, 5'd0, 4'd0, 2'd0);
            check_out("post_rst_idle", 1'b0, 4'd0, 0);
        end
        for (int a = 0; a < 32; a++) begin
            apply(1'b1, 2'd3, 5'(a), 1'b0, 5'd0, 4'd0, 2'd0);
            apply(1'b0, 2'd3, 5'(a), 1'b0, 5'd0, 4'd0, 2'd0);
            check_out($sformatf("user_cleared%0d", a), 1'b0, 4'd0, 0);
        end

        // Entry 31 plays, sequencer wrap is an ordinary address change.
        apply(1'b1, 2'd2, 5'd31, 1'b0, 5'd0, 4'd0, 2'd0);
        apply(1'b0, 2'd2, 5'd31, 1'b0, 5'd0, 4'd0, 2'd0);
        check_out("addr31", 1'b1, 4'd4, 4 * DU);
        apply(1'b0, 2'd2, 5'd0, 1'b0, 5'd0, 4'd0, 2'd0);
        check("wrap.fetch", {31'd0, isvalid}, 32'd0);
        apply(1'b0, 2'd2, 5'd0, 1'b0, 5'd0, 4'd0, 2'd0);
        check_out("wrap", 1'b1, 4'd1, DU);

        // song_load wins over a simultaneous address change.
        apply(1'b1, 2'd0, 5'd2, 1'b0, 5'd0, 4'd0, 2'd0);
        check("prio.active", {30'd0, active_song}, 32'd0);
        check("prio.fetch", {31'd0, isvalid}, 32'd0);
        apply(1'b0, 2'd1, 5'd2, 1'b0, 5'd0, 4'd0, 2'd0);
        check_out("prio", 1'b1, 4'd5, 3 * DU);

        // Randomized traffic against the reference model.
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 32; a++) mem[s][a] = ref_rom(s, a);
        for (int a = 0; a < 32; a++) mem[3][a] = {4'd15, 2'd0};
        m_song = 0; m_last = 0; m_pend = 1'b0; m_play = 1'b0;
        e_note = 4'd0; e_dur = 0; e_ack = 1'b0;
        address = 5'd0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic ld, we, pend_now, play_before, e_valid;
            logic [1:0] sel, wd;
            logic [4:0] addr, wa;
            logic [3:0] wn;
            logic [5:0] e;
            int r, last_before;
            ld = ($urandom_range(0, 9) == 0);
            sel = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            addr = (r < 2) ? address : (r == 2) ? address + 5'd1 : 5'($urandom_range(0, 31));
            we = ($urandom_range(0, 3) == 0);
            wa = 5'($urandom_range(0, 31));
            wn = 4'($urandom_range(0, 15));
            wd = 2'($urandom_range(0, 3));
            pend_now = m_pend; play_before = m_play; last_before = m_last;
            if (pend_now) begin
                e = mem[m_song][addr];
                m_last = addr;
                if (e[5:2] == 4'd15) begin
                    m_play = 1'b0; e_note = 4'd0; e_dur = 0;
                end else begin
                    m_play = 1'b1; e_note = e[5:2]; e_dur = (int'(e[1:0]) + 1) * DU;
                end
            end
            m_pend = ld || (!pend_now && play_before && (int'(addr) != last_before));
            if (ld) m_song = sel;
            e_valid = m_play && !m_pend;
            if (we) mem[3][wa] = {wn, wd};
            e_ack = we;
            apply(ld, sel, addr, we, wa, wn, wd);
            check_out($sformatf("rnd%0d", cyc), e_valid, e_note, e_dur);
            check($sformatf("rnd%0d.wr_ack", cyc), {31'd0, wr_ack}, {31'd0, e_ack});
            check($sformatf("rnd%0d.active", cyc), {30'd0, active_song}, m_song);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
